// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the framed single-wire byte receiver.
package serial_rx_pkg;

    localparam int DATA_BITS       = 8;
    localparam int CNT_W           = $clog2(DATA_BITS);
    localparam int FRAME_LEN_PAR   = 11;
    localparam int FRAME_LEN_NOPAR = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

endpackage

// File: rtl/serial_byte_rx_if.sv
// Serial line in, received byte plus status out; STATE exposes the receiver FSM for checkers.
interface serial_byte_rx_if;
    import serial_rx_pkg::*;

    // SIN is sampled only on cycles with BIT_EN=1. LOAD is a one-cycle strobe with no
    // back-pressure: D_OUT/PERR/FERR are valid with it and hold until the next LOAD.
    logic                 SIN;
    logic                 BIT_EN;
    logic [DATA_BITS-1:0] D_OUT;
    logic                 LOAD;
    logic                 PERR;
    logic                 FERR;
    logic                 BUSY;
    state_t               STATE;

    modport master (
        output SIN, BIT_EN,
        input  D_OUT, LOAD, PERR, FERR, BUSY, STATE
    );

    modport slave (
        input  SIN, BIT_EN,
        output D_OUT, LOAD, PERR, FERR, BUSY, STATE
    );

endinterface

// File: rtl/serial_byte_rx.sv
// Serial-to-parallel byte receiver: start detect, 8-bit shift, optional even parity, stop check.
// All outputs are registered; one LOAD per completed frame, errored frames included.
module serial_byte_rx
    import serial_rx_pkg::*;
#(
    parameter bit PARITY_EN = 1'b1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             CLK,
    input  logic             CLR,
    serial_byte_rx_if.slave  bus
);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 par_q, par_d;
    logic                 load_q, load_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q, busy_d;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.BIT_EN) begin
            case (state_q)
                IDLE:    if (!bus.SIN) state_d = DATA;
                DATA:    if (cnt_q == CNT_W'(DATA_BITS - 1)) state_d = PARITY_EN ? PARITY : STOP;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next values; LOAD defaults low so it never lasts more than one cycle.
    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        dout_d  = dout_q;
        par_d   = par_q;
        load_d  = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        busy_d  = busy_q;
        if (bus.BIT_EN) begin
            case (state_q)
                IDLE: begin
                    if (!bus.SIN) begin
                        cnt_d  = '0;
                        busy_d = 1'b1;
                    end
                end
                DATA: begin
                    if (MSB_FIRST) shreg_d = {shreg_q[DATA_BITS-2:0], bus.SIN};
                    else           shreg_d = {bus.SIN, shreg_q[DATA_BITS-1:1]};
                    cnt_d = cnt_q + 1'b1;
                end
                PARITY: par_d = bus.SIN;
                STOP: begin
                    dout_d = shreg_q;
                    perr_d = PARITY_EN ? ((^shreg_q) ^ par_q) : 1'b0;
                    ferr_d = !bus.SIN;
                    load_d = 1'b1;
                    busy_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            cnt_q   <= '0;
            shreg_q <= '0;
            dout_q  <= '0;
            par_q   <= 1'b0;
            load_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            par_q   <= par_d;
            load_q  <= load_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.D_OUT = dout_q;
    assign bus.LOAD  = load_q;
    assign bus.PERR  = perr_q;
    assign bus.FERR  = ferr_q;
    assign bus.BUSY  = busy_q;
    assign bus.STATE = state_q;

endmodule

// File: tb/tb_serial_byte_rx.sv
// Directed bench: default receiver (parity, LSB first) and a no-parity MSB-first receiver.
module tb_serial_byte_rx;
    import serial_rx_pkg::*;

    logic CLK = 1'b0;
    logic CLR = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Expected entries are {ferr, perr, data}.
    logic [9:0] exp_a_q[$];
    logic [9:0] exp_b_q[$];
    logic [9:0] e_a, e_b;
    int         load_b_cyc[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    serial_byte_rx_if ia ();
    serial_byte_rx_if ib ();

    serial_byte_rx dut_a (
        .CLK (CLK),
        .CLR (CLR),
        .bus (ia.slave)
    );

    serial_byte_rx #(.PARITY_EN(1'b0), .MSB_FIRST(1'b1)) dut_b (
        .CLK (CLK),
        .CLR (CLR),
        .bus (ib.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboards: every LOAD must match the oldest expected frame.
    always @(negedge CLK) begin
        if (ia.LOAD === 1'b1) begin
            if (exp_a_q.size() == 0) begin
                chk("a_unexpected_load", ia.LOAD, 0);
            end else begin
                e_a = exp_a_q.pop_front();
                chk("a_dout", ia.D_OUT, e_a[7:0]);
                chk("a_perr", ia.PERR, e_a[8]);
                chk("a_ferr", ia.FERR, e_a[9]);
            end
        end
        if (ib.LOAD === 1'b1) begin
            load_b_cyc.push_back(cyc);
            if (exp_b_q.size() == 0) begin
                chk("b_unexpected_load", ib.LOAD, 0);
            end else begin
                e_b = exp_b_q.pop_front();
                chk("b_dout", ib.D_OUT, e_b[7:0]);
                chk("b_perr", ib.PERR, e_b[8]);
                chk("b_ferr", ib.FERR, e_b[9]);
            end
        end
    end

    // One strobed bit; BUSY must be low before the start edge and high after it.
    task automatic bit_a(input logic b, input int i);
        @(negedge CLK);
        if (i == 0) chk("a_busy_before_start", ia.BUSY, 0);
        if (i == 1) chk("a_busy_after_start", ia.BUSY, 1);
        ia.SIN    = b;
        ia.BIT_EN = 1'b1;
    endtask

    // Frame vector bit 0 is the start bit, sent first.
    task automatic frame_a(input logic [10:0] v, input logic [9:0] exp);
        exp_a_q.push_back(exp);
        for (int i = 0; i < 11; i++) bit_a(v[i], i);
    endtask

    task automatic idle_a(input int n, input logic en);
        repeat (n) begin
            @(negedge CLK);
            ia.SIN    = 1'b1;
            ia.BIT_EN = en;
        end
    endtask

    task automatic sparse_frame_a(input logic [10:0] v, input logic [9:0] exp);
        exp_a_q.push_back(exp);
        for (int i = 0; i < 11; i++) begin
            bit_a(v[i], i);
            for (int k = 0; k < 3; k++) begin
                @(negedge CLK);
                if (i == 10 && k == 0) chk("sparse_load_latency", ia.LOAD, 1);
                if (i == 10 && k == 1) chk("sparse_load_one_cycle", ia.LOAD, 0);
                ia.BIT_EN = 1'b0;
                ia.SIN    = ~v[i];
            end
        end
    endtask

    task automatic frame_b(input logic [9:0] v, input logic [7:0] exp);
        exp_b_q.push_back({2'b00, exp});
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            ib.SIN    = v[i];
            ib.BIT_EN = 1'b1;
        end
    endtask

    task automatic idle_b(input int n);
        repeat (n) begin
            @(negedge CLK);
            ib.SIN    = 1'b1;
            ib.BIT_EN = 1'b0;
        end
    endtask

    initial begin
        ia.SIN = 1'b1; ia.BIT_EN = 1'b0;
        ib.SIN = 1'b1; ib.BIT_EN = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_dout", ia.D_OUT, 8'h00);
        chk("rst_load", ia.LOAD, 0);
        chk("rst_perr", ia.PERR, 0);
        chk("rst_ferr", ia.FERR, 0);
        chk("rst_busy", ia.BUSY, 0);
        chk("rst_state", ia.STATE, IDLE);
        chk("rst_b_dout", ib.D_OUT, 8'h00);
        CLR = 1'b0;
        idle_a(2, 1'b1);

        // 0xA5: line 0,1,0,1,0,0,1,0,1,0,1
        frame_a({1'b1, 1'b0, 8'hA5, 1'b0}, {1'b0, 1'b0, 8'hA5});
        idle_a(1, 1'b0);
        chk("a5_load_cycle", ia.LOAD, 1);
        chk("a5_busy_low_at_load", ia.BUSY, 0);
        idle_a(1, 1'b0);
        chk("a5_load_one_cycle", ia.LOAD, 0);
        chk("a5_dout_hold", ia.D_OUT, 8'hA5);
        idle_a(3, 1'b1);

        // 0x01 with parity 0 is a parity error; 0x03 with parity 0 clears it
        frame_a({1'b1, 1'b0, 8'h01, 1'b0}, {1'b0, 1'b1, 8'h01});
        frame_a({1'b1, 1'b0, 8'h03, 1'b0}, {1'b0, 1'b0, 8'h03});
        idle_a(3, 1'b1);

        // 0x5A with stop bit 0, then a long high line must produce nothing
        frame_a({1'b0, 1'b0, 8'h5A, 1'b0}, {1'b1, 1'b0, 8'h5A});
        idle_a(30, 1'b1);
        chk("ferr_hold_dout", ia.D_OUT, 8'h5A);
        chk("ferr_hold_flag", ia.FERR, 1);

        // Start plus four data bits, then asynchronous clear
        for (int i = 0; i < 5; i++) bit_a(i == 0 ? 1'b0 : 1'b1, i);
        @(negedge CLK);
        ia.BIT_EN = 1'b0;
        CLR = 1'b1;
        #1;
        chk("clr_dout", ia.D_OUT, 8'h00);
        chk("clr_ferr", ia.FERR, 0);
        chk("clr_perr", ia.PERR, 0);
        chk("clr_busy", ia.BUSY, 0);
        chk("clr_load", ia.LOAD, 0);
        chk("clr_state", ia.STATE, IDLE);
        @(negedge CLK);
        CLR = 1'b0;
        idle_a(2, 1'b1);
        frame_a({1'b1, 1'b0, 8'h3C, 1'b0}, {1'b0, 1'b0, 8'h3C});
        idle_a(3, 1'b1);

        // No parity, MSB first, back-to-back; 0x69 on the wire LSB-first order is 0x96 MSB first
        frame_b({1'b1, 8'hFF, 1'b0}, 8'hFF);
        frame_b({1'b1, 8'h00, 1'b0}, 8'h00);
        frame_b({1'b1, 8'h69, 1'b0}, 8'h96);
        idle_b(4);
        chk("b_load_count", load_b_cyc.size(), 3);
        if (load_b_cyc.size() == 3) begin
            chk("b_spacing_1", load_b_cyc[1] - load_b_cyc[0], FRAME_LEN_NOPAR);
            chk("b_spacing_2", load_b_cyc[2] - load_b_cyc[1], FRAME_LEN_NOPAR);
        end

        // One strobe every 4 cycles, line inverted between strobes
        sparse_frame_a({1'b1, 1'b0, 8'hC3, 1'b0}, {1'b0, 1'b0, 8'hC3});
        idle_a(4, 1'b0);

        chk("a_drain", exp_a_q.size(), 0);
        chk("b_drain", exp_b_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
